// File: rtl/semafor_monitor.sv
// rtl/semafor_monitor.sv - traffic-light lamp sequence monitor
//
// Tracks the car lamp phase (RED -> GREEN -> YELLOW -> RED). It measures
// how long each phase lasts, counts completed cycles and raises sticky
// error flags.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rosu_i/galben_i/verde_i   car red/yellow/green lamps
//   rosu_p_i/verde_p_i        pedestrian red/green lamps
//   err_clr_i           synchronous clear of sticky error flags
//   phase_o             tracked phase: 00 INIT, 01 RED, 10 GREEN, 11 YELLOW
//   dur_last_o          duration in cycles of the last completed phase
//   dur_valid_o         one-cycle pulse when dur_last_o updates
//   cycle_cnt_o         completed RED->GREEN->YELLOW->RED cycles (wraps)
//   err_lamp_o, err_seq_o, err_conflict_o   sticky error flags
//   err_any_o           OR of the error flags
module semafor_monitor #(
  parameter int WIDTH = 6,
  parameter int CYC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rosu_i,
  input  logic             galben_i,
  input  logic             verde_i,
  input  logic             rosu_p_i,
  input  logic             verde_p_i,
  input  logic             err_clr_i,
  output logic [1:0]       phase_o,
  output logic [WIDTH-1:0] dur_last_o,
  output logic             dur_valid_o,
  output logic [CYC_W-1:0] cycle_cnt_o,
  output logic             err_lamp_o,
  output logic             err_seq_o,
  output logic             err_conflict_o,
  output logic             err_any_o
);

  typedef enum logic [1:0] {
    S_INIT   = 2'b00,
    S_RED    = 2'b01,
    S_GREEN  = 2'b10,
    S_YELLOW = 2'b11
  } state_e;

  state_e           state_q, state_d;
  state_e           car_state, succ_state;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dur_last_q, dur_last_d;
  logic             dur_valid_q, dur_valid_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             err_lamp_q, err_lamp_d;
  logic             err_seq_q, err_seq_d;
  logic             err_conf_q, err_conf_d;
  logic             car_valid, ped_valid;
  logic             det_lamp, det_seq, det_conf;

  // Lamp decode and the legal successor of the current phase
  always_comb begin
    car_valid = 1'b1;
    car_state = S_INIT;
    case ({rosu_i, galben_i, verde_i})
      3'b100:  car_state = S_RED;
      3'b001:  car_state = S_GREEN;
      3'b010:  car_state = S_YELLOW;
      default: car_valid = 1'b0;
    endcase
    ped_valid = rosu_p_i ^ verde_p_i;
    det_conf  = verde_p_i & (verde_i | galben_i);
    case (state_q)
      S_RED:    succ_state = S_GREEN;
      S_GREEN:  succ_state = S_YELLOW;
      S_YELLOW: succ_state = S_RED;
      default:  succ_state = S_INIT;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dur_last_d  = dur_last_q;
    dur_valid_d = 1'b0;
    cyc_d       = cyc_q;
    det_lamp    = 1'b0;
    det_seq     = 1'b0;
    if (!car_valid || !ped_valid) begin
      // Broken lamp pattern: abandon the phase without reporting a duration
      det_lamp = 1'b1;
      state_d  = S_INIT;
      cnt_d    = '0;
    end else if (state_q == S_INIT) begin
      state_d = car_state;
      cnt_d   = WIDTH'(1);
    end else if (car_state == state_q) begin
      if (cnt_q != {WIDTH{1'b1}}) cnt_d = cnt_q + WIDTH'(1);
    end else begin
      // Phase change between two real phases: legal or not, report it
      dur_last_d  = cnt_q;
      dur_valid_d = 1'b1;
      state_d     = car_state;
      cnt_d       = WIDTH'(1);
      if (car_state != succ_state) det_seq = 1'b1;
      else if (state_q == S_YELLOW) cyc_d = cyc_q + CYC_W'(1);
    end
    // A fresh detection overrides a simultaneous clear
    err_lamp_d = (err_lamp_q & ~err_clr_i) | det_lamp;
    err_seq_d  = (err_seq_q & ~err_clr_i) | det_seq;
    err_conf_d = (err_conf_q & ~err_clr_i) | det_conf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      dur_last_q  <= '0;
      dur_valid_q <= 1'b0;
      cyc_q       <= '0;
      err_lamp_q  <= 1'b0;
      err_seq_q   <= 1'b0;
      err_conf_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dur_last_q  <= dur_last_d;
      dur_valid_q <= dur_valid_d;
      cyc_q       <= cyc_d;
      err_lamp_q  <= err_lamp_d;
      err_seq_q   <= err_seq_d;
      err_conf_q  <= err_conf_d;
    end
  end

  assign phase_o        = state_q;
  assign dur_last_o     = dur_last_q;
  assign dur_valid_o    = dur_valid_q;
  assign cycle_cnt_o    = cyc_q;
  assign err_lamp_o     = err_lamp_q;
  assign err_seq_o      = err_seq_q;
  assign err_conflict_o = err_conf_q;
  assign err_any_o      = err_lamp_q | err_seq_q | err_conf_q;

endmodule

// File: tb/tb_semafor_monitor.sv
// tb/tb_semafor_monitor.sv - self-checking bench for semafor_monitor
module tb_semafor_monitor;
  localparam int WIDTH = 6;
  localparam int CYC_W = 8;
  localparam int CNT_MAX = (1 << WIDTH) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rosu = 1'b0, galben = 1'b0, verde = 1'b0;
  logic rosu_p = 1'b1, verde_p = 1'b0, err_clr = 1'b0;
  logic [1:0] phase;
  logic [WIDTH-1:0] dur_last;
  logic dur_valid;
  logic [CYC_W-1:0] cycle_cnt;
  logic err_lamp, err_seq, err_conflict, err_any;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase as 0 INIT, 1 RED, 2 GREEN, 3 YELLOW
  int m_phase, m_cnt, m_last, m_valid, m_cyc;
  bit m_el, m_es, m_ec;

  semafor_monitor #(.WIDTH(WIDTH), .CYC_W(CYC_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .rosu_i(rosu), .galben_i(galben), .verde_i(verde),
    .rosu_p_i(rosu_p), .verde_p_i(verde_p), .err_clr_i(err_clr),
    .phase_o(phase), .dur_last_o(dur_last), .dur_valid_o(dur_valid),
    .cycle_cnt_o(cycle_cnt), .err_lamp_o(err_lamp), .err_seq_o(err_seq),
    .err_conflict_o(err_conflict), .err_any_o(err_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] code_of(input int p);
    case (p)
      1: return 3'b100;
      2: return 3'b001;
      3: return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic int phase_of(input logic [2:0] c);
    for (int p = 1; p <= 3; p++) if (code_of(p) == c) return p;
    return 0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_last = 0; m_valid = 0; m_cyc = 0;
    m_el = 0; m_es = 0; m_ec = 0;
  endtask

  task automatic model_step();
    int car;
    bit d_lamp, d_seq, d_conf;
    car    = phase_of({rosu, galben, verde});
    d_lamp = (car == 0) || (rosu_p == verde_p);
    d_conf = verde_p && (verde || galben);
    d_seq  = 0;
    m_valid = 0;
    if (d_lamp) begin
      m_phase = 0; m_cnt = 0;
    end else if (m_phase == 0) begin
      m_phase = car; m_cnt = 1;
    end else if (car == m_phase) begin
      m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
    end else begin
      m_last = m_cnt; m_valid = 1;
      if (car != (m_phase % 3) + 1) d_seq = 1;
      else if (m_phase == 3) m_cyc = (m_cyc + 1) % (1 << CYC_W);
      m_phase = car; m_cnt = 1;
    end
    m_el = (m_el && !err_clr) || d_lamp;
    m_es = (m_es && !err_clr) || d_seq;
    m_ec = (m_ec && !err_clr) || d_conf;
  endtask

  task automatic compare_all();
    check("phase", 32'(phase), 32'(m_phase));
    check("dur_last", 32'(dur_last), 32'(m_last));
    check("dur_valid", 32'(dur_valid), 32'(m_valid));
    check("cycle_cnt", 32'(cycle_cnt), 32'(m_cyc));
    check("err_lamp", 32'(err_lamp), 32'(m_el));
    check("err_seq", 32'(err_seq), 32'(m_es));
    check("err_conflict", 32'(err_conflict), 32'(m_ec));
    check("err_any", 32'(err_any), 32'(m_el | m_es | m_ec));
  endtask

  // Apply inputs, clock once, advance the model and compare
  task automatic cyc(input logic [2:0] code, input logic rp, input logic vp, input logic clr);
    {rosu, galben, verde} = code;
    rosu_p = rp; verde_p = vp; err_clr = clr;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic hold(input int p, input int n);
    for (int i = 0; i < n; i++) cyc(code_of(p), 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int cur, left, r;
    logic [2:0] code;
    logic rp, vp;
    model_reset();
    #12;
    check("rst_phase", 32'(phase), 0);
    check("rst_dur_last", 32'(dur_last), 0);
    check("rst_cycle_cnt", 32'(cycle_cnt), 0);
    check("rst_err_any", 32'(err_any), 0);
    rst_n = 1'b1;

    // Nominal cycle: RED 10, GREEN 20, YELLOW 3, RED
    hold(1, 10);
    hold(2, 1);
    check("nom_red_dur", 32'(dur_last), 10);
    check("nom_red_valid", 32'(dur_valid), 1);
    hold(2, 19);
    hold(3, 1);
    check("nom_green_dur", 32'(dur_last), 20);
    hold(3, 2);
    hold(1, 1);
    check("nom_yellow_dur", 32'(dur_last), 3);
    check("nom_cycle_cnt", 32'(cycle_cnt), 1);
    check("nom_phase", 32'(phase), 1);
    check("nom_err_any", 32'(err_any), 0);

    // Saturation: GREEN held 100 cycles
    hold(2, 100);
    hold(3, 1);
    check("sat_dur", 32'(dur_last), 63);

    // Illegal RED -> YELLOW
    hold(1, 4);
    hold(3, 1);
    check("seq_err", 32'(err_seq), 1);
    check("seq_phase", 32'(phase), 3);
    check("seq_dur", 32'(dur_last), 4);
    cyc(code_of(3), 1'b1, 1'b0, 1'b1);
    check("seq_clr", 32'(err_seq), 0);

    // Invalid car code during GREEN
    hold(1, 2);
    hold(2, 3);
    cyc(3'b110, 1'b1, 1'b0, 1'b0);
    check("lamp_err", 32'(err_lamp), 1);
    check("lamp_phase", 32'(phase), 0);
    check("lamp_valid", 32'(dur_valid), 0);
    hold(2, 1);
    check("lamp_resume", 32'(phase), 2);
    check("lamp_no_seq", 32'(err_seq), 0);
    cyc(code_of(2), 1'b1, 1'b0, 1'b1);

    // Conflict persists through a clear
    cyc(code_of(2), 1'b0, 1'b1, 1'b0);
    check("conf_set", 32'(err_conflict), 1);
    cyc(code_of(2), 1'b0, 1'b1, 1'b1);
    check("conf_hold", 32'(err_conflict), 1);
    cyc(code_of(2), 1'b1, 1'b0, 1'b1);
    check("conf_clr", 32'(err_conflict), 0);

    // Randomized traffic with occasional faults, clears and resets
    cur = 2; left = 0;
    for (int n = 0; n < 4000; n++) begin
      if (left == 0) begin
        r = $urandom_range(0, 99);
        cur = (r < 85) ? (cur % 3) + 1 : $urandom_range(1, 3);
        left = $urandom_range(1, 80);
      end
      left--;
      code = code_of(cur);
      rp = (cur != 1); vp = (cur == 1);
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do code = 3'($urandom_range(0, 7)); while (phase_of(code) != 0);
      end else if (r < 4) begin
        rp = 1'($urandom_range(0, 1)); vp = rp;
      end else if (r < 6) begin
        rp = 1'b0; vp = 1'b1;
      end
      cyc(code, rp, vp, ($urandom_range(0, 99) < 4));
      if ($urandom_range(0, 999) < 3) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/semafor_monitor.md
SEMAFOR_MONITOR -- requirements
Module: semafor_monitor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 6: width of the phase-duration counter and of dur_last.
REQ-002 The block SHALL have parameter CYC_W, default 8: width of the completed-cycle counter.
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rosu, galben, verde  input  1 each  car red/yellow/green lamps, synchronous to clk.
REQ-006 rosu_p, verde_p  input  1 each  pedestrian red/green lamps, synchronous to clk.
REQ-007 err_clr  input  1  synchronous clear of all sticky error flags.
REQ-008 phase  output  2  current tracked phase: 00 INIT, 01 RED, 10 GREEN, 11 YELLOW.
REQ-009 dur_last  output  WIDTH  cycle count of the last completed phase.
REQ-010 dur_valid  output  1  one-cycle pulse when dur_last is updated.
REQ-011 cycle_cnt  output  CYC_W  number of completed RED->GREEN->YELLOW->RED cycles.
REQ-012 err_lamp, err_seq, err_conflict  output  1 each  sticky error flags; err_any output 1 = OR of the three.

Function
REQ-013 Car lamp code {rosu,galben,verde} SHALL be valid only as 100 (RED), 001 (GREEN), 010 (YELLOW); all other codes are invalid.
REQ-014 Pedestrian code SHALL be valid only when exactly one of rosu_p, verde_p is 1.
REQ-015 Inputs SHALL be decoded combinationally and sampled at each rising edge; all outputs SHALL be registered, reflecting the condition sampled at that same edge.
REQ-016 FSM states SHALL be INIT, RED, GREEN, YELLOW; legal transitions: RED->GREEN, GREEN->YELLOW, YELLOW->RED; same code -> stay.
REQ-017 From INIT, a valid car code SHALL move the FSM to the matching state with no err_seq, no dur_valid, counter loaded to 1.
REQ-018 A valid code different from the current non-INIT state but not a legal successor (RED->YELLOW, GREEN->RED, YELLOW->GREEN) SHALL set err_seq and move the FSM to the state of the new code.
REQ-019 An invalid car code or invalid pedestrian code SHALL set err_lamp, move the FSM to INIT, clear the duration counter to 0, and SHALL NOT pulse dur_valid.
REQ-020 verde_p=1 while verde=1 or galben=1 SHALL set err_conflict; this check SHALL be evaluated in every state including INIT.
REQ-021 Duration counter SHALL load 1 on entry to a phase and increment by 1 each cycle the phase persists, saturating at 2^WIDTH-1 without wrap.
REQ-022 On any phase change between two non-INIT states (legal or illegal), dur_last SHALL take the counter value of the phase being left and dur_valid SHALL be 1 for exactly that one cycle.
REQ-023 cycle_cnt SHALL increment by 1 on each legal YELLOW->RED transition and wrap modulo 2^CYC_W.
REQ-024 Error flags SHALL stay set until err_clr; err_clr=1 SHALL clear them, except that an error detected in the same cycle as err_clr SHALL win and leave its flag set.
REQ-025 Multiple errors in the same cycle SHALL set all corresponding flags simultaneously.

Reset
REQ-026 While rst_n=0: phase=00, dur_last=0, dur_valid=0, cycle_cnt=0, all error flags and err_any=0, duration counter=0.
REQ-027 Reset asserted mid-phase SHALL abort the phase with no dur_valid; after release the FSM SHALL resume from INIT per REQ-017.

Verification
REQ-028 Reset release, then RED+rosu_p for 10 cycles, GREEN 20, YELLOW 3, RED -> dur_valid pulses with dur_last 10, 20, 3; cycle_cnt=1; phase sequence 01,10,11,01; no errors.
REQ-029 WIDTH=6, GREEN held 100 cycles then YELLOW -> dur_last=63 (saturated), no wrap.
REQ-030 RED then direct YELLOW -> err_seq=1, err_any=1, phase=11, dur_valid with RED duration; err_clr pulse -> err_seq=0 next edge.
REQ-031 Car code 110 for one cycle during GREEN -> err_lamp=1, phase=00, no dur_valid; next GREEN code -> phase=10, no err_seq.
REQ-032 verde_p=1 with verde=1 -> err_conflict=1; err_clr asserted in a cycle where the conflict persists -> err_conflict stays 1.
REQ-033 Connected to the traffic light controller with button pulses after 65 and 80 cycles -> only legal sequences, cycle_cnt increments once per completed YELLOW->RED, err_any remains 0.
